// File: rtl/hd_pkg.sv
// hd_pkg: shared FSM encoding, default sizing and chunk/score types
// for the HD similarity stage. No ports.
package hd_pkg;

  localparam int HD_DHV_SIZE    = 4000;
  localparam int HD_LANES       = 16;
  localparam int HD_DIM_WIDTH   = 16;
  localparam int HD_FTWIDTH     = 8;
  localparam int HD_MAX_CLASSES = 32;
  localparam int HD_ACC_WIDTH   = 32;

  localparam int CHUNKS = HD_DHV_SIZE / HD_LANES;
  localparam int CLA_ADDR_WIDTH =
    $clog2(HD_MAX_CLASSES * CHUNKS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    ARGMAX,
    RESULT
  } state_e;

  typedef logic [HD_LANES-1:0][HD_DIM_WIDTH-1:0]
    enc_chunk_t;
  typedef logic [HD_LANES-1:0][HD_FTWIDTH-1:0]
    cls_chunk_t;
  typedef logic signed [HD_ACC_WIDTH-1:0] score_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hd_dot_lanes.sv
// hd_dot_lanes: combinational LANES-wide signed dot product.
// Ports: enc (encoded chunk), cls (class chunk), sum (OUT_W signed).
module hd_dot_lanes
  import hd_pkg::*;
#(
  parameter int LANES     = HD_LANES,
  parameter int DIM_WIDTH = HD_DIM_WIDTH,
  parameter int FTWIDTH   = HD_FTWIDTH,
  parameter int OUT_W     = HD_ACC_WIDTH
) (
  input  logic [LANES-1:0][DIM_WIDTH-1:0] enc,
  input  logic [LANES-1:0][FTWIDTH-1:0]   cls,
  output logic signed [OUT_W-1:0]         sum
);

  localparam int PW = DIM_WIDTH + FTWIDTH;

  logic signed [PW-1:0] prod [LANES];

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed(enc[i]) * $signed(cls[i]);
      sum = sum + OUT_W'(prod[i]);
    end
  end

endmodule

// File: rtl/hd_similarity_engine.sv
// hd_similarity_engine: chunked dot-product scoring of an encoded
// hypervector against C class vectors, followed by argmax.
// Ports: clk/reset, start+class_num, enc_* handshake, class_* memory
// read port, res_valid/res_ready, max_val, max_index, cfg_err, busy.
// Build option SCORE_SAT_EN: saturating accumulate plus sat_flag.
module hd_similarity_engine
  import hd_pkg::*;
#(
  parameter int DHV_SIZE    = HD_DHV_SIZE,
  parameter int LANES       = HD_LANES,
  parameter int DIM_WIDTH   = HD_DIM_WIDTH,
  parameter int FTWIDTH     = HD_FTWIDTH,
  parameter int MAX_CLASSES = HD_MAX_CLASSES,
  parameter int ACC_WIDTH   = HD_ACC_WIDTH,
  localparam int NCH = DHV_SIZE / LANES,
  localparam int AW  = $clog2(MAX_CLASSES * NCH),
  localparam int CW  = $clog2(MAX_CLASSES) + 1,
  localparam int IW  = $clog2(MAX_CLASSES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CW-1:0]                class_num,
  input  logic                         enc_valid,
  input  logic [LANES*DIM_WIDTH-1:0]   enc_data,
  output logic                         enc_ready,
  output logic [AW-1:0]                class_addr,
  output logic                         class_re,
  input  logic [LANES*FTWIDTH-1:0]     class_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [ACC_WIDTH-1:0]  max_val,
  output logic [IW-1:0]                max_index,
  output logic                         cfg_err,
`ifdef SCORE_SAT_EN
  output logic                         sat_flag,
`endif
  output logic                         busy
);

  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W =
    max_int(ACC_WIDTH, DIM_WIDTH + FTWIDTH + $clog2(LANES));

  state_e state;

  logic [CW-1:0] cnum;
  logic [CW-1:0] mac_cnt;
  logic [IW-1:0] arg_cnt;
  logic [IW-1:0] rd_idx;
  logic [KW-1:0] k;
  logic          rd_vld;
  logic          bad_cfg;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [LANES*DIM_WIDTH-1:0] enc_buf;

  logic signed [ACC_WIDTH-1:0] score [MAX_CLASSES];
  logic signed [ACC_WIDTH-1:0] best_val;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic [IW-1:0]               best_idx;
  logic signed [SUM_W-1:0]     dot;

  hd_dot_lanes #(
    .LANES     (LANES),
    .DIM_WIDTH (DIM_WIDTH),
    .FTWIDTH   (FTWIDTH),
    .OUT_W     (SUM_W)
  ) u_dot (
    .enc (enc_buf),
    .cls (class_data),
    .sum (dot)
  );

`ifdef SCORE_SAT_EN
  localparam int EW = SUM_W + 1;
  localparam logic signed [EW-1:0] SMAX =
    EW'($signed({1'b0, {(ACC_WIDTH-1){1'b1}}}));
  localparam logic signed [EW-1:0] SMIN =
    EW'($signed({1'b1, {(ACC_WIDTH-1){1'b0}}}));

  logic signed [EW-1:0] acc_ext;
  logic                 acc_ovf;
  logic                 sat_q;

  // Full-precision add, then clamp into the score range.
  always_comb begin
    acc_ext = EW'(score[rd_idx]) + EW'(dot);
    acc_ovf = 1'b1;
    if (acc_ext > SMAX) begin
      acc_new = SMAX[ACC_WIDTH-1:0];
    end else if (acc_ext < SMIN) begin
      acc_new = SMIN[ACC_WIDTH-1:0];
    end else begin
      acc_new = acc_ext[ACC_WIDTH-1:0];
      acc_ovf = 1'b0;
    end
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    acc_new = score[rd_idx] + ACC_WIDTH'(dot);
  end
`endif

  assign bad_cfg = (class_num == '0) ||
                   (class_num > CW'(MAX_CLASSES));

  // Read c = mac_cnt while mac_cnt < C; last MAC cycle drains.
  assign class_re = (state == MAC) && (mac_cnt != cnum);
  assign class_addr = class_re
    ? AW'(int'(mac_cnt) * NCH + int'(k))
    : addr_q;

  assign enc_ready = (state == LOAD);
  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);
  assign max_val   = best_val;
  assign max_index = best_idx;
  assign cfg_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnum     <= '0;
      mac_cnt  <= '0;
      arg_cnt  <= '0;
      rd_idx   <= '0;
      rd_vld   <= 1'b0;
      k        <= '0;
      addr_q   <= '0;
      enc_buf  <= '0;
      best_val <= '0;
      best_idx <= '0;
      err_q    <= 1'b0;
`ifdef SCORE_SAT_EN
      sat_q    <= 1'b0;
`endif
      for (int c = 0; c < MAX_CLASSES; c++) begin
        score[c] <= '0;
      end
    end else begin
      rd_vld <= class_re;
      rd_idx <= mac_cnt[IW-1:0];
      addr_q <= class_addr;

      // Data for the read issued last cycle lands now.
      if (rd_vld) begin
        score[rd_idx] <= acc_new;
`ifdef SCORE_SAT_EN
        if (acc_ovf) sat_q <= 1'b1;
`endif
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            cnum     <= class_num;
            k        <= '0;
            best_val <= '0;
            best_idx <= '0;
            err_q    <= bad_cfg;
`ifdef SCORE_SAT_EN
            sat_q    <= 1'b0;
`endif
            for (int c = 0; c < MAX_CLASSES; c++) begin
              score[c] <= '0;
            end
            state <= bad_cfg ? RESULT : LOAD;
          end
        end
        LOAD: begin
          if (enc_valid) begin
            enc_buf <= enc_data;
            mac_cnt <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          if (mac_cnt == cnum) begin
            mac_cnt <= '0;
            if (k == KW'(NCH - 1)) begin
              arg_cnt <= '0;
              state   <= ARGMAX;
            end else begin
              k     <= k + 1'b1;
              state <= LOAD;
            end
          end else begin
            mac_cnt <= mac_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          // Strictly greater keeps the lowest index on ties.
          if (arg_cnt == '0 || score[arg_cnt] > best_val) begin
            best_val <= score[arg_cnt];
            best_idx <= arg_cnt;
          end
          if (CW'(arg_cnt) == cnum - 1'b1) begin
            state <= RESULT;
          end else begin
            arg_cnt <= arg_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_similarity_engine.sv
// tb_hd_similarity_engine: directed + random runs against a
// score/argmax reference model; 32-bit and 8-bit score instances.
module tb_hd_similarity_engine;

  localparam int LANES = 4;
  localparam int DHV   = 8;
  localparam int MAXC  = 4;
  localparam int DW    = 16;
  localparam int FW    = 8;
  localparam int NCH   = DHV / LANES;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic enc_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [2:0] class_num = '0;
  logic [LANES*DW-1:0] enc_data = '0;
  logic [LANES*FW-1:0] class_data = '0;

  logic enc_ready, class_re, res_valid, cfg_err, busy;
  logic [2:0] class_addr;
  logic signed [31:0] max_val;
  logic [1:0] max_index;

  logic b_enc_ready, b_class_re, b_res_valid, b_cfg_err, b_busy;
  logic [2:0] b_class_addr;
  logic signed [7:0] b_max_val;
  logic [1:0] b_max_index;
`ifdef SCORE_SAT_EN
  logic a_sat, b_sat;
`endif

  logic [LANES*DW-1:0] chunk [NCH];
  logic [LANES*FW-1:0] mem [MAXC*NCH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (class_re) class_data <= mem[class_addr];

  hd_similarity_engine #(
    .DHV_SIZE(DHV), .LANES(LANES), .DIM_WIDTH(DW),
    .FTWIDTH(FW), .MAX_CLASSES(MAXC), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .class_num(class_num), .enc_valid(enc_valid),
    .enc_data(enc_data), .enc_ready(enc_ready),
    .class_addr(class_addr), .class_re(class_re),
    .class_data(class_data), .res_valid(res_valid),
    .res_ready(res_ready), .max_val(max_val),
    .max_index(max_index), .cfg_err(cfg_err),
`ifdef SCORE_SAT_EN
    .sat_flag(a_sat),
`endif
    .busy(busy)
  );

  // Same stimulus, 8-bit scores; runs in lockstep with dut.
  hd_similarity_engine #(
    .DHV_SIZE(DHV), .LANES(LANES), .DIM_WIDTH(DW),
    .FTWIDTH(FW), .MAX_CLASSES(MAXC), .ACC_WIDTH(8)
  ) dut8 (
    .clk(clk), .reset(reset), .start(start),
    .class_num(class_num), .enc_valid(enc_valid),
    .enc_data(enc_data), .enc_ready(b_enc_ready),
    .class_addr(b_class_addr), .class_re(b_class_re),
    .class_data(class_data), .res_valid(b_res_valid),
    .res_ready(res_ready), .max_val(b_max_val),
    .max_index(b_max_index), .cfg_err(b_cfg_err),
`ifdef SCORE_SAT_EN
    .sat_flag(b_sat),
`endif
    .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input int e, input int c0,
                             input int c1, input int c2,
                             input int c3);
    int cv [4];
    cv = '{c0, c1, c2, c3};
    for (int kk = 0; kk < NCH; kk++)
      for (int i = 0; i < LANES; i++)
        chunk[kk][i*DW +: DW] = DW'(e);
    for (int cl = 0; cl < MAXC; cl++)
      for (int kk = 0; kk < NCH; kk++)
        for (int i = 0; i < LANES; i++)
          mem[cl*NCH+kk][i*FW +: FW] = FW'(cv[cl]);
  endtask

  task automatic set_random();
    for (int kk = 0; kk < NCH; kk++)
      for (int i = 0; i < LANES; i++)
        chunk[kk][i*DW +: DW] = DW'($urandom);
    for (int a = 0; a < MAXC*NCH; a++)
      mem[a] = 32'($urandom);
  endtask

  // Scores as plain integer sums; the 8-bit score folds each
  // chunk's total in with clamp or modulo-256 wrap.
  task automatic model(input int c, output int ix,
                       output longint v, output int ix8,
                       output int v8, output bit sat8);
    longint s;
    int s8, d, t;
    ix = 0; v = 0; ix8 = 0; v8 = 0; sat8 = 0;
    if (c < 1 || c > MAXC) return;
    for (int cl = 0; cl < c; cl++) begin
      s = 0;
      s8 = 0;
      for (int kk = 0; kk < NCH; kk++) begin
        d = 0;
        for (int i = 0; i < LANES; i++)
          d += int'($signed(chunk[kk][i*DW +: DW])) *
               int'($signed(mem[cl*NCH+kk][i*FW +: FW]));
        s += d;
        t = s8 + d;
`ifdef SCORE_SAT_EN
        if (t > 127) begin t = 127; sat8 = 1; end
        else if (t < -128) begin t = -128; sat8 = 1; end
`else
        t = t & 255;
        if (t > 127) t -= 256;
`endif
        s8 = t;
      end
      if (cl == 0 || s > v) begin v = s; ix = cl; end
      if (cl == 0 || s8 > v8) begin v8 = s8; ix8 = cl; end
    end
  endtask

  // Starts a run at a negedge; returns at the negedge where
  // res_valid is first seen (or one cycle into MAC for k=1).
  task automatic run(input int c, input int stall1,
                     input bit abort_k1, output int lat,
                     output bit saw_ready);
    int kidx, st, cyc;
    kidx = 0; st = 0; cyc = 1; saw_ready = 0; lat = 0;
    class_num = 3'(c);
    start = 1;
    @(negedge clk);
    start = 0;
    while (!res_valid && cyc < 400) begin
      enc_valid = 0;
      if (abort_k1 && kidx == 2) return;
      if (enc_ready) begin
        saw_ready = 1;
        if (kidx == 1 && st < stall1) begin
          st++;
        end else begin
          enc_valid = 1;
          enc_data = (kidx < NCH) ? chunk[kidx] : '0;
          kidx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    enc_valid = 0;
    lat = cyc;
  endtask

  task automatic release_res(input string tag, input int hold,
                             input bit start_rel);
    logic signed [31:0] v;
    logic [1:0] ix;
    bit moved, seen;
    v = max_val; ix = max_index;
    moved = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid || max_val !== v || max_index !== ix)
        moved = 1;
    end
    chk({tag, "_held"}, moved, 0);
    res_ready = 1;
    if (start_rel) begin
      start = 1;
      class_num = 3'd2;
    end
    @(negedge clk);
    res_ready = 0;
    start = 0;
    chk({tag, "_idle"}, busy, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1;
    end
    chk({tag, "_quiet"}, seen, 0);
  endtask

  task automatic run_check(input string tag, input int c,
                           input int stall1, input int hold,
                           input bit start_rel);
    int lat, eix, eix8, ev8, elat;
    longint ev;
    bit esat, saw, bad;
    bad = (c < 1 || c > MAXC);
    model(c, eix, ev, eix8, ev8, esat);
    elat = bad ? 1 : 1 + NCH*(c+2) + c + stall1;
    run(c, stall1, 0, lat, saw);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_idx"}, max_index, eix);
    chk({tag, "_val"}, max_val, ev);
    chk({tag, "_err"}, cfg_err, bad);
    chk({tag, "_rdy"}, saw, !bad);
    chk({tag, "_b_vld"}, b_res_valid, 1);
    chk({tag, "_b_err"}, b_cfg_err, bad);
    chk({tag, "_b_idx"}, b_max_index, eix8);
    chk({tag, "_b_val"}, b_max_val, ev8);
`ifdef SCORE_SAT_EN
    chk({tag, "_a_sat"}, a_sat, 0);
    chk({tag, "_b_sat"}, b_sat, esat);
`endif
    release_res(tag, hold, start_rel);
  endtask

  initial begin
    int lat;
    bit saw;
    repeat (2) @(negedge clk);
    chk("rst_vld", res_valid, 0);
    chk("rst_rdy", enc_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", class_re, 0);
    chk("rst_val", max_val, 0);
    chk("rst_err", cfg_err, 0);
`ifdef SCORE_SAT_EN
    chk("rst_sat", b_sat, 0);
`endif
    reset = 0;
    @(negedge clk);

    set_uniform(1, 1, 2, -1, 0);
    run_check("runA", 3, 0, 0, 0);
    chk("runA_idx_lit", max_index, 1);

    set_uniform(1, 3, 0, 3, 0);
    run_check("tie", 3, 0, 0, 1);

    run_check("c0", 0, 0, 0, 0);
    run_check("c5", 5, 0, 0, 0);

    set_uniform(1, 1, 2, -1, 0);
    run_check("stall", 3, 7, 5, 0);

    run(3, 0, 1, lat, saw);
    chk("mid_busy", busy, 1);
    chk("mid_re", class_re, 1);
    chk("mid_addr", class_addr, 1);
    #2 reset = 1;
    #1;
    chk("ar_vld", res_valid, 0);
    chk("ar_rdy", enc_ready, 0);
    chk("ar_re", class_re, 0);
    chk("ar_addr", class_addr, 0);
    chk("ar_busy", busy, 0);
    chk("ar_val", max_val, 0);
    chk("ar_idx", max_index, 0);
    chk("ar_err", cfg_err, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("ar_quiet", res_valid, 0);
    run_check("rerun", 3, 0, 0, 0);

    set_uniform(127, 127, 0, 0, 0);
    run_check("sat", 1, 0, 0, 0);
`ifdef SCORE_SAT_EN
    chk("sat_b_127", b_max_val, 127);
`else
    chk("sat_b_wrap", b_max_val, 8);
`endif

    for (int r = 0; r < 6; r++) begin
      set_random();
      run_check($sformatf("rnd%0d", r),
                int'($urandom_range(1, 4)), 0,
                int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
